// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two pipeline requesters, the shared memory bus
// and the arbiter. The arbiter connects through the slave modport; the
// environment (pipeline stages plus bus) connects through the master modport.
interface mem_bus_arbiter_if;
    // Instruction-fetch requester channel
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    // Memory-stage data requester channel
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // Pipeline flush (exception / eret)
    logic        flush;

    // Shared SRAM-like bus
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    // Arbiter side
    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        input  flush,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    // Requester / bus side
    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        output flush,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-way arbiter for a single SRAM-like memory bus. Data requests win by
// default; a starvation counter forces an instruction grant after
// STARVE_LIMIT consecutive data grants made while inst_req was waiting.
// One transaction is outstanding at a time: attributes are latched at grant,
// the response is routed back to the owner, and a flushed instruction fetch
// still completes on the bus but its response is swallowed.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT_W = 4'(STARVE_LIMIT);
    localparam logic       OWNER_INST     = 1'b0;
    localparam logic       OWNER_DATA     = 1'b1;

    state_t      state_q,      state_d;
    logic        owner_q,      owner_d;
    logic        discard_q,    discard_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        lat_wr_q,     lat_wr_d;
    logic [1:0]  lat_size_q,   lat_size_d;
    logic [31:0] lat_addr_q,   lat_addr_d;
    logic [31:0] lat_wdata_q,  lat_wdata_d;

    logic        data_wins;
    logic        bus_req_c;
    logic        inst_addr_ok_c;
    logic        data_addr_ok_c;
    logic        inst_data_ok_c;
    logic        data_data_ok_c;
    logic [31:0] inst_rdata_c;
    logic [31:0] data_rdata_c;

    // State and latched-transaction registers; reset abandons any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_INST;
            discard_q    <= 1'b0;
            starve_cnt_q <= 4'd0;
            lat_wr_q     <= 1'b0;
            lat_size_q   <= 2'd0;
            lat_addr_q   <= 32'd0;
            lat_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            discard_q    <= discard_d;
            starve_cnt_q <= starve_cnt_d;
            lat_wr_q     <= lat_wr_d;
            lat_size_q   <= lat_size_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
        end
    end

    // Grant decision, bus handshake sequencing and response routing
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        discard_d      = discard_q;
        starve_cnt_d   = starve_cnt_q;
        lat_wr_d       = lat_wr_q;
        lat_size_d     = lat_size_q;
        lat_addr_d     = lat_addr_q;
        lat_wdata_d    = lat_wdata_q;
        bus_req_c      = 1'b0;
        inst_addr_ok_c = 1'b0;
        data_addr_ok_c = 1'b0;
        inst_data_ok_c = 1'b0;
        data_data_ok_c = 1'b0;
        inst_rdata_c   = 32'd0;
        data_rdata_c   = 32'd0;

        data_wins = bus_if.data_req &
                    (~bus_if.inst_req | (starve_cnt_q < STARVE_LIMIT_W));

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (data_wins) begin
                    owner_d     = OWNER_DATA;
                    lat_wr_d    = bus_if.data_wr;
                    lat_size_d  = bus_if.data_size;
                    lat_addr_d  = bus_if.data_addr;
                    lat_wdata_d = bus_if.data_wdata;
                    state_d     = ADDR;
                    if (bus_if.inst_req) begin
                        if (starve_cnt_q != 4'hF) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end else if (bus_if.inst_req) begin
                    owner_d      = OWNER_INST;
                    lat_wr_d     = bus_if.inst_wr;
                    lat_size_d   = bus_if.inst_size;
                    lat_addr_d   = bus_if.inst_addr;
                    lat_wdata_d  = bus_if.inst_wdata;
                    state_d      = ADDR;
                    starve_cnt_d = 4'd0;
                end
            end

            ADDR: begin
                bus_req_c = 1'b1;
                if (bus_if.flush && (owner_q == OWNER_INST)) begin
                    discard_d = 1'b1;
                end
                if (bus_if.bus_addr_ok) begin
                    if (owner_q == OWNER_DATA) begin
                        data_addr_ok_c = 1'b1;
                    end else begin
                        inst_addr_ok_c = 1'b1;
                    end
                    state_d = DATA;
                end
            end

            DATA: begin
                if (bus_if.flush && (owner_q == OWNER_INST)) begin
                    discard_d = 1'b1;
                end
                if (bus_if.bus_data_ok) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q) begin
                        if (owner_q == OWNER_DATA) begin
                            data_data_ok_c = 1'b1;
                            data_rdata_c   = bus_if.bus_rdata;
                        end else begin
                            inst_data_ok_c = 1'b1;
                            inst_rdata_c   = bus_if.bus_rdata;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_if.bus_req      = bus_req_c;
    assign bus_if.bus_wr       = lat_wr_q;
    assign bus_if.bus_size     = lat_size_q;
    assign bus_if.bus_addr     = lat_addr_q;
    assign bus_if.bus_wdata    = lat_wdata_q;
    assign bus_if.inst_addr_ok = inst_addr_ok_c;
    assign bus_if.data_addr_ok = data_addr_ok_c;
    assign bus_if.inst_data_ok = inst_data_ok_c;
    assign bus_if.data_data_ok = data_data_ok_c;
    assign bus_if.inst_rdata   = inst_rdata_c;
    assign bus_if.data_rdata   = data_rdata_c;

endmodule
